// File: rtl/spi_slave_byte.sv
// spi_slave_byte: SPI peripheral (slave) byte engine for the ADC board link.
// Oversamples SCLK/CS_n/MOSI in the i_Clk domain. Supports modes 0-3 and shifts MSB first.
// Provides a TX ready/valid holding register and a 1-cycle RX data-valid pulse.
// Optional feature macro: SPI_SLAVE_ERR_CNT_EN adds a saturating error counter
// (o_Err_Count) that counts underruns and aborted partial bytes, with synchronous clear i_Err_Clr.
module spi_slave_byte #(
    parameter int unsigned SYNC_STAGES  = 2,
    parameter logic [7:0]  IDLE_TX_BYTE = 8'h00
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic [1:0] spimode,
    input  logic       i_SPI_Clk,
    input  logic       i_SPI_CS_n,
    input  logic       i_SPI_MOSI,
    output logic       o_SPI_MISO,
    output logic       o_SPI_MISO_OE,
    input  logic [7:0] i_TX_Byte,
    input  logic       i_TX_DV,
    output logic       o_TX_Ready,
    output logic       o_RX_DV,
    output logic [7:0] o_RX_Byte,
`ifdef SPI_SLAVE_ERR_CNT_EN
    input  logic       i_Err_Clr,
    output logic [7:0] o_Err_Count,
`endif
    output logic       o_CS_Active
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_prev_q;
    logic                   sclk_s, cs_n_s, mosi_s;

    logic [1:0] mode_q;
    logic [2:0] bit_cnt_q;
    logic [7:0] tx_shift_q;
    logic [6:0] rx_shift_q;
    logic [7:0] rx_byte_q;
    logic       rx_dv_q;
    logic       miso_q;
    logic [7:0] hold_q;
    logic       hold_full_q;

    logic       lead_edge, trail_edge, sample_edge, drive_edge;
    logic       byte_done;
    logic       hold_take;
    logic [7:0] load_byte;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_n_s = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // Synchronizer chains for the three pins, plus the previous SCLK sample for edge detection
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], i_SPI_Clk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], i_SPI_CS_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_SPI_MOSI};
            sclk_prev_q <= sclk_s;
        end
    end

    // Classify SCLK edges against the latched CPOL/CPHA of the current frame
    always_comb begin
        lead_edge   = (sclk_s != sclk_prev_q) && (sclk_s != mode_q[1]);
        trail_edge  = (sclk_s != sclk_prev_q) && (sclk_s == mode_q[1]);
        sample_edge = mode_q[0] ? trail_edge : lead_edge;
        drive_edge  = mode_q[0] ? lead_edge  : trail_edge;
        byte_done   = (state_q == ST_SHIFT) && !cs_n_s && sample_edge && (bit_cnt_q == 3'd0);
        hold_take   = (state_q == ST_LOAD) && hold_full_q;
        load_byte   = hold_full_q ? hold_q : IDLE_TX_BYTE;
    end

    // FSM state register
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: CS release from any active state returns to IDLE
    always_comb begin
        state_d = state_q;
        if (state_q != ST_IDLE && cs_n_s) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (!cs_n_s) state_d = ST_LOAD;
                ST_LOAD:  state_d = ST_SHIFT;
                ST_SHIFT: if (byte_done) state_d = ST_LOAD;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // FSM outputs: MISO is only driven while the frame is active
    always_comb begin
        o_SPI_MISO_OE = (state_q != ST_IDLE);
        o_SPI_MISO    = (state_q != ST_IDLE) && miso_q;
        o_TX_Ready    = !hold_full_q;
        o_CS_Active   = !cs_n_s;
        o_RX_DV       = rx_dv_q;
        o_RX_Byte     = rx_byte_q;
    end

    // Shift datapath: the bit counter indexes the TX byte, so the bit to drive always matches the next sample.
    // Because the counter wraps from 0 to 7, a trailing edge just after a byte boundary re-drives bit 7.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            mode_q     <= 2'b00;
            bit_cnt_q  <= 3'd7;
            tx_shift_q <= 8'h00;
            rx_shift_q <= 7'h00;
            rx_byte_q  <= 8'h00;
            rx_dv_q    <= 1'b0;
            miso_q     <= 1'b0;
        end else begin
            rx_dv_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    bit_cnt_q <= 3'd7;
                    miso_q    <= 1'b0;
                    if (!cs_n_s) mode_q <= spimode;
                end
                ST_LOAD: begin
                    tx_shift_q <= load_byte;
                    bit_cnt_q  <= 3'd7;
                    if (!mode_q[0]) miso_q <= load_byte[7];
                end
                ST_SHIFT: begin
                    if (!cs_n_s) begin
                        if (sample_edge) begin
                            rx_shift_q <= {rx_shift_q[5:0], mosi_s};
                            bit_cnt_q  <= bit_cnt_q - 3'd1;
                            if (bit_cnt_q == 3'd0) begin
                                rx_byte_q <= {rx_shift_q, mosi_s};
                                rx_dv_q   <= 1'b1;
                            end
                        end
                        if (drive_edge) miso_q <= tx_shift_q[bit_cnt_q];
                    end
                end
                default: ;
            endcase
        end
    end

    // TX holding register: a load coinciding with LOAD emptying it is kept for the next byte
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            hold_q      <= 8'h00;
            hold_full_q <= 1'b0;
        end else if (i_TX_DV && (!hold_full_q || hold_take)) begin
            hold_q      <= i_TX_Byte;
            hold_full_q <= 1'b1;
        end else if (hold_take) begin
            hold_full_q <= 1'b0;
        end
    end

`ifdef SPI_SLAVE_ERR_CNT_EN
    logic       underrun, partial_abort;
    logic [1:0] err_inc;
    logic [8:0] err_sum;
    logic [7:0] err_cnt_d, err_cnt_q;

    assign underrun      = (state_q == ST_LOAD) && !hold_full_q;
    assign partial_abort = (state_q != ST_IDLE) && cs_n_s && (bit_cnt_q != 3'd7);
    assign err_inc       = {1'b0, underrun} + {1'b0, partial_abort};
    assign err_sum       = {1'b0, err_cnt_q} + {7'd0, err_inc};
    assign err_cnt_d     = i_Err_Clr ? 8'h00 : (err_sum[8] ? 8'hFF : err_sum[7:0]);
    assign o_Err_Count   = err_cnt_q;

    // Saturating error counter; clear takes priority over increments
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            err_cnt_q <= 8'h00;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_spi_slave_byte.sv
// Bench for spi_slave_byte: bus-level SPI master model with RX and MISO scoreboards.
module tb_spi_slave_byte;

    localparam int HALF = 100;

    logic       i_Clk = 1'b0;
    logic       i_Rst_L;
    logic [1:0] spimode;
    logic       i_SPI_Clk;
    logic       i_SPI_CS_n;
    logic       i_SPI_MOSI;
    logic       o_SPI_MISO;
    logic       o_SPI_MISO_OE;
    logic [7:0] i_TX_Byte;
    logic       i_TX_DV;
    logic       o_TX_Ready;
    logic       o_RX_DV;
    logic [7:0] o_RX_Byte;
    logic       o_CS_Active;
`ifdef SPI_SLAVE_ERR_CNT_EN
    logic       i_Err_Clr;
    logic [7:0] o_Err_Count;
`endif

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_rx[$];
    logic [7:0] exp_miso[$];

    spi_slave_byte dut (
        .i_Clk         (i_Clk),
        .i_Rst_L       (i_Rst_L),
        .spimode       (spimode),
        .i_SPI_Clk     (i_SPI_Clk),
        .i_SPI_CS_n    (i_SPI_CS_n),
        .i_SPI_MOSI    (i_SPI_MOSI),
        .o_SPI_MISO    (o_SPI_MISO),
        .o_SPI_MISO_OE (o_SPI_MISO_OE),
        .i_TX_Byte     (i_TX_Byte),
        .i_TX_DV       (i_TX_DV),
        .o_TX_Ready    (o_TX_Ready),
        .o_RX_DV       (o_RX_DV),
        .o_RX_Byte     (o_RX_Byte),
`ifdef SPI_SLAVE_ERR_CNT_EN
        .i_Err_Clr     (i_Err_Clr),
        .o_Err_Count   (o_Err_Count),
`endif
        .o_CS_Active   (o_CS_Active)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // RX scoreboard: every o_RX_DV pulse must match the oldest expected byte
    always @(negedge i_Clk) begin
        if (i_Rst_L === 1'b1 && o_RX_DV === 1'b1) begin
            if (exp_rx.size() == 0)
                check_eq("rx_unexpected_dv", 32'(o_RX_DV), 32'd0);
            else
                check_eq("rx_byte", 32'(o_RX_Byte), 32'(exp_rx.pop_front()));
        end
    end

    task automatic frame_begin(input logic [1:0] m);
        spimode   = m;
        i_SPI_Clk = m[1];
        #(HALF);
        i_SPI_CS_n = 1'b0;
        #(HALF);
        check_eq("cs_active", 32'(o_CS_Active), 32'd1);
        check_eq("miso_oe", 32'(o_SPI_MISO_OE), 32'd1);
    endtask

    task automatic frame_end();
        #(HALF);
        i_SPI_CS_n = 1'b1;
        #(4*HALF);
    endtask

    // Master side of one byte (or the first nbits of it) in mode m
    task automatic xfer(input logic [1:0] m, input logic [7:0] mo, input int nbits);
        logic [7:0] mi;
        mi = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            if (!m[0]) begin
                i_SPI_MOSI = mo[i];
                #(HALF);
                i_SPI_Clk = ~m[1];
                mi[i] = o_SPI_MISO;
                #(HALF);
                i_SPI_Clk = m[1];
            end else begin
                #(HALF);
                i_SPI_Clk  = ~m[1];
                i_SPI_MOSI = mo[i];
                #(HALF);
                i_SPI_Clk = m[1];
                mi[i] = o_SPI_MISO;
            end
        end
        if (nbits == 8)
            check_eq("miso_byte", 32'(mi), 32'(exp_miso.pop_front()));
    endtask

    task automatic tx_load(input logic [7:0] b);
        int n;
        n = 0;
        while (o_TX_Ready !== 1'b1 && n < 500) begin
            @(negedge i_Clk);
            n++;
        end
        if (o_TX_Ready !== 1'b1)
            check_eq("tx_ready_timeout", 32'(o_TX_Ready), 32'd1);
        @(negedge i_Clk);
        i_TX_Byte = b;
        i_TX_DV   = 1'b1;
        @(negedge i_Clk);
        i_TX_DV   = 1'b0;
    endtask

    initial begin
        i_Rst_L    = 1'b0;
        spimode    = 2'd0;
        i_SPI_Clk  = 1'b0;
        i_SPI_CS_n = 1'b1;
        i_SPI_MOSI = 1'b0;
        i_TX_Byte  = 8'h00;
        i_TX_DV    = 1'b0;
`ifdef SPI_SLAVE_ERR_CNT_EN
        i_Err_Clr  = 1'b0;
`endif
        #23;
        check_eq("rst_miso", 32'(o_SPI_MISO), 32'd0);
        check_eq("rst_miso_oe", 32'(o_SPI_MISO_OE), 32'd0);
        check_eq("rst_tx_ready", 32'(o_TX_Ready), 32'd1);
        check_eq("rst_rx_dv", 32'(o_RX_DV), 32'd0);
        check_eq("rst_rx_byte", 32'(o_RX_Byte), 32'd0);
        check_eq("rst_cs_active", 32'(o_CS_Active), 32'd0);
`ifdef SPI_SLAVE_ERR_CNT_EN
        check_eq("rst_err_count", 32'(o_Err_Count), 32'd0);
`endif
        @(negedge i_Clk);
        i_Rst_L = 1'b1;
        repeat (4) @(negedge i_Clk);

        // Mode 0, TX loaded before the frame
        tx_load(8'h3C);
        check_eq("tx_ready_after_load", 32'(o_TX_Ready), 32'd0);
        exp_miso.push_back(8'h3C);
        exp_rx.push_back(8'hA5);
        frame_begin(2'd0);
        check_eq("tx_ready_after_LOAD", 32'(o_TX_Ready), 32'd1);
        xfer(2'd0, 8'hA5, 8);
        frame_end();

        // Mode 3, two back-to-back bytes; second TX loaded when ready; spimode changed mid-frame
        tx_load(8'h12);
        exp_miso.push_back(8'h12);
        exp_miso.push_back(8'h34);
        exp_rx.push_back(8'hF0);
        exp_rx.push_back(8'h0F);
        fork
            begin
                frame_begin(2'd3);
                xfer(2'd3, 8'hF0, 8);
                xfer(2'd3, 8'h0F, 8);
                frame_end();
            end
            begin
                tx_load(8'h34);
                spimode = 2'd0;
            end
        join

        // Mode 1 underrun
`ifdef SPI_SLAVE_ERR_CNT_EN
        @(negedge i_Clk);
        i_Err_Clr = 1'b1;
        @(negedge i_Clk);
        i_Err_Clr = 1'b0;
        check_eq("err_after_clear", 32'(o_Err_Count), 32'd0);
`endif
        exp_miso.push_back(8'h00);
        exp_rx.push_back(8'hC3);
        frame_begin(2'd1);
`ifdef SPI_SLAVE_ERR_CNT_EN
        check_eq("err_underrun", 32'(o_Err_Count), 32'd1);
`endif
        xfer(2'd1, 8'hC3, 8);
        frame_end();

        // Abort after 5 bits, then a clean frame
        frame_begin(2'd0);
        xfer(2'd0, 8'hFF, 5);
        frame_end();
        check_eq("rx_byte_kept_on_abort", 32'(o_RX_Byte), 32'hC3);
        exp_miso.push_back(8'h00);
        exp_rx.push_back(8'h81);
        frame_begin(2'd0);
        xfer(2'd0, 8'h81, 8);
        frame_end();
        check_eq("rx_pending_after_abort", 32'(exp_rx.size()), 32'd0);

        // Second TX strobe while the holding register is full is ignored
        tx_load(8'hAA);
        @(negedge i_Clk);
        i_TX_Byte = 8'h55;
        i_TX_DV   = 1'b1;
        @(negedge i_Clk);
        i_TX_DV   = 1'b0;
        check_eq("tx_ready_still_full", 32'(o_TX_Ready), 32'd0);
        exp_miso.push_back(8'hAA);
        exp_rx.push_back(8'h5A);
        frame_begin(2'd0);
        xfer(2'd0, 8'h5A, 8);
        frame_end();
        exp_miso.push_back(8'h00);
        exp_rx.push_back(8'h66);
        frame_begin(2'd0);
        xfer(2'd0, 8'h66, 8);
        frame_end();

        // Reset mid-byte in mode 2
        frame_begin(2'd2);
        tx_load(8'h77);
        check_eq("tx_ready_before_rst", 32'(o_TX_Ready), 32'd0);
        xfer(2'd2, 8'hE7, 4);
        i_Rst_L = 1'b0;
        #1;
        check_eq("mid_rst_miso", 32'(o_SPI_MISO), 32'd0);
        check_eq("mid_rst_miso_oe", 32'(o_SPI_MISO_OE), 32'd0);
        check_eq("mid_rst_tx_ready", 32'(o_TX_Ready), 32'd1);
        check_eq("mid_rst_rx_dv", 32'(o_RX_DV), 32'd0);
        check_eq("mid_rst_rx_byte", 32'(o_RX_Byte), 32'd0);
        check_eq("mid_rst_cs_active", 32'(o_CS_Active), 32'd0);
        i_SPI_CS_n = 1'b1;
        i_SPI_Clk  = 1'b1;
        #(4*HALF);
        @(negedge i_Clk);
        i_Rst_L = 1'b1;
        repeat (4) @(negedge i_Clk);
        exp_miso.push_back(8'h00);
        exp_rx.push_back(8'h3E);
        frame_begin(2'd2);
        xfer(2'd2, 8'h3E, 8);
        frame_end();

        check_eq("rx_pending_final", 32'(exp_rx.size()), 32'd0);
        check_eq("miso_pending_final", 32'(exp_miso.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
